// File: rtl/uart_rx_if.sv
// SOC-facing signal bundle of the UART receiver: the serial line in, plus the
// hold-until-read byte handshake and status pulses out.
`timescale 1ns/1ps

interface uart_rx_if;
    logic       RXD;
    logic       RD;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    modport slave  (input RXD, RD, output DATA, VALID, FRAME_ERR, OVERRUN, BUSY);
    modport master (output RXD, RD, input DATA, VALID, FRAME_ERR, OVERRUN, BUSY);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RXD, samples each bit mid-cell and holds the
// received byte until the SOC reads it, flagging framing errors and overruns.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic     CLK,
    input  logic     RESET,
    uart_rx_if.slave bus
);
    localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div, div_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data, data_n;
    logic             valid, valid_n;
    logic             frame_err, frame_err_n;
    logic             overrun, overrun_n;
    logic             rx_m, rx_s;

    // Synchroniser presets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.RXD;
            rx_s <= rx_m;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            div       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        // NOTE: every next value is defaulted first so no path leaves it unassigned (no latch).
        state_n     = state;
        div_n       = div + DIV_W'(1);
        idx_n       = idx;
        shift_n     = shift;
        data_n      = data;
        valid_n     = valid;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        if (bus.RD && valid)
            valid_n = 1'b0;

        case (state)
            S_IDLE: begin
                div_n = '0;
                if (!rx_s)
                    state_n = S_START;
            end
            S_START: begin
                if (div == DIV_HALF) begin
                    div_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (div == DIV_LAST) begin
                    div_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7)
                        state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (div == DIV_LAST) begin
                    div_n = '0;
                    if (rx_s) begin
                        // A delivery coinciding with a read keeps the new byte and is not an overrun.
                        data_n    = shift;
                        valid_n   = 1'b1;
                        overrun_n = valid && !bus.RD;
                        state_n   = S_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                div_n = '0;
                if (rx_s)
                    state_n = S_IDLE;
            end
            default: begin
                div_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.DATA      = data;
    assign bus.VALID     = valid;
    assign bus.FRAME_ERR = frame_err;
    assign bus.OVERRUN   = overrun;
    assign bus.BUSY      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8 clk/bit instance for the directed and random scenarios and a
// default-parameter instance fed with skewed baud; a byte/handshake model predicts outputs.
`timescale 1ns/1ps

module tb_uart_rx;
    localparam int  F_CPB  = 8;
    localparam int  D_CPB  = 86;
    localparam real F_BIT  = 80.0;
    localparam real D_BIT  = 860.0;
    // Edges from the start-bit drive to the delivery edge: 2 sync + 1 detect + half bit + 9 bits.
    localparam int  F_LAT  = 2 + 1 + F_CPB / 2 + 9 * F_CPB;

    logic CLK;
    logic RESET;

    uart_rx_if fi ();
    uart_rx_if di ();

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD(125_000)) dut_fast (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (fi)
    );

    uart_rx dut_def (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (di)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the SOC-visible state for the fast instance.
    logic [7:0] m_data;
    logic       m_valid;
    int         m_fe = 0;
    int         m_ov = 0;

    // Pulse monitors: count clock cycles each status output is high.
    int f_fe = 0, f_ov = 0, d_fe = 0, d_ov = 0;
    always @(negedge CLK) begin
        if (fi.FRAME_ERR === 1'b1) f_fe++;
        if (fi.OVERRUN   === 1'b1) f_ov++;
        if (di.FRAME_ERR === 1'b1) d_fe++;
        if (di.OVERRUN   === 1'b1) d_ov++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_deliver(input logic [7:0] b, input bit rd_same);
        if (m_valid && !rd_same) m_ov++;
        m_data  = b;
        m_valid = 1'b1;
    endtask

    task automatic model_read();
        m_valid = 1'b0;
    endtask

    task automatic sync_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic v, input real ns);
        if (sel) di.RXD = v;
        else     fi.RXD = v;
        #(ns);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input real bit_ns);
        drive_bit(sel, 1'b0, bit_ns);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i], bit_ns);
        drive_bit(sel, stop, bit_ns);
    endtask

    task automatic pulse_rd(input bit sel);
        @(posedge CLK);
        #1;
        if (sel) di.RD = 1'b1; else fi.RD = 1'b1;
        @(posedge CLK);
        #1;
        if (sel) di.RD = 1'b0; else fi.RD = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, input int budget, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            @(negedge CLK);
            cycles++;
            ok = sel ? (di.VALID === 1'b1) : (fi.VALID === 1'b1);
        end
    endtask

    task automatic test_reset();
        RESET  = 1'b0;
        fi.RXD = 1'b1; fi.RD = 1'b0;
        di.RXD = 1'b1; di.RD = 1'b0;
        m_data = 8'h00; m_valid = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({fi.DATA, fi.VALID, fi.FRAME_ERR, fi.OVERRUN, fi.BUSY} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_fast: got %h required 000", {fi.DATA, fi.VALID, fi.FRAME_ERR, fi.OVERRUN, fi.BUSY});
        end
        n_checks++;
        if ({di.DATA, di.VALID, di.FRAME_ERR, di.OVERRUN, di.BUSY} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_def: got %h required 000", {di.DATA, di.VALID, di.FRAME_ERR, di.OVERRUN, di.BUSY});
        end
        sync_edge();
        RESET = 1'b1;
        repeat (6) @(negedge CLK);
        n_checks++;
        if (fi.BUSY !== 1'b0 || di.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b%b required 00", fi.BUSY, di.BUSY);
        end
    endtask

    task automatic test_basic();
        int cyc;
        bit ok;
        sync_edge();
        fork
            send_frame(1'b0, 8'hA5, 1'b1, F_BIT);
            wait_valid(1'b0, 200, cyc, ok);
        join
        model_deliver(8'hA5, 1'b0);
        n_checks++;
        if (!ok || cyc !== F_LAT + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b after %0d cycles required 1 after %0d", ok, cyc, F_LAT + 1);
        end
        n_checks++;
        if (fi.DATA !== m_data) begin
            n_fail++;
            $display("FAIL basic_data: got %h required %h", fi.DATA, m_data);
        end
        pulse_rd(1'b0);
        model_read();
        @(negedge CLK);
        n_checks++;
        if (fi.VALID !== m_valid || fi.DATA !== m_data) begin
            n_fail++;
            $display("FAIL basic_read: got valid=%b data=%h required valid=%b data=%h", fi.VALID, fi.DATA, m_valid, m_data);
        end
    endtask

    task automatic test_glitch();
        bit busy_seen = 1'b0;
        sync_edge();
        fi.RXD = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        fi.RXD = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            if (fi.BUSY === 1'b1) busy_seen = 1'b1;
        end
        n_checks++;
        if (!busy_seen || fi.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: got seen=%b final=%b required seen=1 final=0", busy_seen, fi.BUSY);
        end
        n_checks++;
        if (fi.VALID !== m_valid || f_fe !== m_fe || f_ov !== m_ov) begin
            n_fail++;
            $display("FAIL glitch_quiet: got valid=%b fe=%0d ov=%0d required valid=%b fe=%0d ov=%0d",
                     fi.VALID, f_fe, f_ov, m_valid, m_fe, m_ov);
        end
    endtask

    task automatic test_frame_err();
        int cyc;
        bit ok;
        sync_edge();
        send_frame(1'b0, 8'h3C, 1'b0, F_BIT);
        #(3.0 * F_BIT);
        m_fe++;
        @(negedge CLK);
        n_checks++;
        if (fi.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_busy_held: got %b required 1", fi.BUSY);
        end
        n_checks++;
        if (f_fe !== m_fe || fi.VALID !== m_valid || fi.DATA !== m_data) begin
            n_fail++;
            $display("FAIL ferr_outputs: got fe=%0d valid=%b data=%h required fe=%0d valid=%b data=%h",
                     f_fe, fi.VALID, fi.DATA, m_fe, m_valid, m_data);
        end
        sync_edge();
        fi.RXD = 1'b1;
        repeat (6) @(negedge CLK);
        n_checks++;
        if (fi.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_busy_release: got %b required 0", fi.BUSY);
        end
        sync_edge();
        fork
            send_frame(1'b0, 8'h81, 1'b1, F_BIT);
            wait_valid(1'b0, 200, cyc, ok);
        join
        model_deliver(8'h81, 1'b0);
        n_checks++;
        if (!ok || fi.DATA !== m_data || f_fe !== m_fe) begin
            n_fail++;
            $display("FAIL ferr_recover: got valid=%b data=%h fe=%0d required valid=1 data=%h fe=%0d",
                     ok, fi.DATA, f_fe, m_data, m_fe);
        end
        pulse_rd(1'b0);
        model_read();
    endtask

    task automatic test_overrun();
        sync_edge();
        send_frame(1'b0, 8'h11, 1'b1, F_BIT);
        model_deliver(8'h11, 1'b0);
        send_frame(1'b0, 8'h22, 1'b1, F_BIT);
        model_deliver(8'h22, 1'b0);
        @(negedge CLK);
        n_checks++;
        if (f_ov !== m_ov || fi.DATA !== m_data || fi.VALID !== m_valid) begin
            n_fail++;
            $display("FAIL overrun: got ov=%0d data=%h valid=%b required ov=%0d data=%h valid=%b",
                     f_ov, fi.DATA, fi.VALID, m_ov, m_data, m_valid);
        end
        pulse_rd(1'b0);
        model_read();

        sync_edge();
        send_frame(1'b0, 8'h11, 1'b1, F_BIT);
        model_deliver(8'h11, 1'b0);
        fork
            send_frame(1'b0, 8'h22, 1'b1, F_BIT);
            begin
                repeat (F_LAT - 1) @(posedge CLK);
                #1 fi.RD = 1'b1;
                @(posedge CLK);
                #1 fi.RD = 1'b0;
            end
        join
        model_deliver(8'h22, 1'b1);
        @(negedge CLK);
        n_checks++;
        if (f_ov !== m_ov || fi.DATA !== m_data || fi.VALID !== m_valid) begin
            n_fail++;
            $display("FAIL rd_same_cycle: got ov=%0d data=%h valid=%b required ov=%0d data=%h valid=%b",
                     f_ov, fi.DATA, fi.VALID, m_ov, m_data, m_valid);
        end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        bit ok;
        sync_edge();
        fork
            send_frame(1'b0, 8'hFF, 1'b1, F_BIT);
            begin
                repeat (44) @(posedge CLK);
                #3 RESET = 1'b0;
                m_data  = 8'h00;
                m_valid = 1'b0;
                #1;
                n_checks++;
                if ({fi.DATA, fi.VALID, fi.FRAME_ERR, fi.OVERRUN, fi.BUSY} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL reset_async: got %h required 000", {fi.DATA, fi.VALID, fi.FRAME_ERR, fi.OVERRUN, fi.BUSY});
                end
                repeat (16) @(posedge CLK);
                #1 RESET = 1'b1;
            end
        join
        sync_edge();
        fork
            send_frame(1'b0, 8'h5A, 1'b1, F_BIT);
            wait_valid(1'b0, 200, cyc, ok);
        join
        model_deliver(8'h5A, 1'b0);
        n_checks++;
        if (!ok || cyc !== F_LAT + 1 || fi.DATA !== m_data || f_ov !== m_ov) begin
            n_fail++;
            $display("FAIL reset_then_rx: got valid=%b cyc=%0d data=%h ov=%0d required valid=1 cyc=%0d data=%h ov=%0d",
                     ok, cyc, fi.DATA, f_ov, F_LAT + 1, m_data, m_ov);
        end
        pulse_rd(1'b0);
        model_read();
    endtask

    task automatic test_random();
        int  cyc;
        bit  ok;
        logic [7:0] b;
        int  gap;
        for (int k = 0; k < 8; k++) begin
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 20));
            @(posedge CLK);
            repeat (gap) @(posedge CLK);
            #1;
            fork
                send_frame(1'b0, b, 1'b1, F_BIT);
                wait_valid(1'b0, 200, cyc, ok);
            join
            model_deliver(b, 1'b0);
            n_checks++;
            if (!ok || cyc !== F_LAT + 1 || fi.DATA !== m_data) begin
                n_fail++;
                $display("FAIL random_%0d: got valid=%b cyc=%0d data=%h required valid=1 cyc=%0d data=%h",
                         k, ok, cyc, fi.DATA, F_LAT + 1, m_data);
            end
            pulse_rd(1'b0);
            model_read();
        end
        n_checks++;
        if (f_fe !== m_fe || f_ov !== m_ov) begin
            n_fail++;
            $display("FAIL random_status: got fe=%0d ov=%0d required fe=%0d ov=%0d", f_fe, f_ov, m_fe, m_ov);
        end
    endtask

    task automatic test_default_params();
        logic [7:0] exp_q[$];
        real        skew[3];
        logic [7:0] bytes[3];
        int         d_fe0, d_ov0;
        bytes = '{8'h00, 8'hFF, 8'h55};
        skew  = '{1.02, 0.98, 1.02};
        d_fe0 = d_fe;
        d_ov0 = d_ov;
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        sync_edge();
        fork
            for (int i = 0; i < 3; i++) send_frame(1'b1, bytes[i], 1'b1, D_BIT * skew[i]);
            for (int k = 0; k < 3; k++) begin
                int   cyc;
                bit   ok;
                logic [7:0] exp;
                wait_valid(1'b1, 12 * D_CPB, cyc, ok);
                exp = exp_q.pop_front();
                n_checks++;
                if (!ok || di.DATA !== exp) begin
                    n_fail++;
                    $display("FAIL default_byte_%0d: got valid=%b data=%h required valid=1 data=%h", k, ok, di.DATA, exp);
                end
                pulse_rd(1'b1);
            end
        join
        repeat (4) @(negedge CLK);
        n_checks++;
        if (d_fe !== d_fe0 || d_ov !== d_ov0) begin
            n_fail++;
            $display("FAIL default_status: got fe=%0d ov=%0d required fe=%0d ov=%0d", d_fe - d_fe0, d_ov - d_ov0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_random();
        test_default_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the board serial link: deserialises 8N1 UART frames arriving on the RXD pin into bytes for the SOC.
- Sits between the top-level RXD input and SOC logic, for example an LED display or a future CPU I/O register.
- Presents each byte through a hold-until-read handshake.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 10_000_000: input clock frequency in Hz (E1 board oscillator).
- BAUD, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, 86 at defaults): clocks per bit. Must be ≥ 4.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active low; one clock domain (CLK).
- RXD  in  1  serial line. Asynchronous to CLK. Idle high.
- RD  in  1  one-cycle read strobe; consumes the held byte.
- DATA  out  8  last good received byte, LSB = first data bit on the line.
- VALID  out  1  DATA holds an unread byte.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: good byte completed while the previous byte was still unread.
- BUSY  out  1  high whenever the state machine is not in IDLE.

Behaviour:
- Reset, asserted asynchronously with RESET=0:
  - DATA=0, VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - State IDLE, bit counter 0, clock divider 0.
  - Synchroniser flops preset to 1, so no false start bit on release.
  - Reset asserted mid-frame aborts the frame; a partial byte is never delivered.
- Input synchroniser: RXD passes through two flops to give rx_s. All decisions below use rx_s, which adds 2 cycles of latency.
- Divider: counter div counts 0..CLKS_PER_BIT-1. It restarts at 0 on every state entry.
- State machine:
  - IDLE: BUSY=0. When rx_s=0, go to START with div=0.
  - START: at div = CLKS_PER_BIT/2 - 1 (mid start bit):
    - rx_s=0: go to DATA, bit index=0, div=0.
    - rx_s=1: glitch; return to IDLE with no output activity.
  - DATA: at div = CLKS_PER_BIT-1, sample rx_s into shift[index] (LSB first) and increment index. After index 7 is sampled, go to STOP.
  - STOP: at div = CLKS_PER_BIT-1 (mid stop bit):
    - rx_s=1: DATA <= shift, VALID <= 1, go to IDLE.
    - rx_s=0: FRAME_ERR pulses for 1 cycle, shift is discarded, DATA and VALID are unchanged. Go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from being parsed as repeated frames.
- Because the stop bit is sampled mid-bit, a start edge in the second half of the stop bit is detected without loss. Back-to-back frames must be received with no gaps.
- Handshake:
  - RD=1 with VALID=1 clears VALID the next cycle. RD with VALID=0 is ignored.
  - Delivery of a new good byte while VALID=1 and RD=0: DATA is overwritten, VALID stays 1, OVERRUN pulses 1 cycle.
  - Delivery in the same cycle as RD=1: the new byte wins. VALID stays 1, and there is no OVERRUN.
- Output timing: DATA, VALID, FRAME_ERR and OVERRUN update 1 cycle after the stop-bit sample.
- Arithmetic: div width is clog2(CLKS_PER_BIT); bit index is 3 bits. No other arithmetic.

Test Plan:
- Basic receive:
  - Stimulus: CLK_FREQ=1_000_000, BAUD=125_000 (8 clk/bit); send 0xA5 framed 8N1.
  - Required: VALID rises at the mid-stop-bit sample +1 cycle, with DATA=0xA5.
  - Then RD pulse: VALID=0 the next cycle, DATA stays 0xA5.
- Glitch rejection:
  - Stimulus: RXD low for 2 clocks in IDLE.
  - Required: BUSY returns to 0 after the half-bit check; VALID, FRAME_ERR and OVERRUN stay 0.
- Framing error:
  - Stimulus: send 0x3C with stop bit 0, holding RXD low for 3 more bit times.
  - Required: one FRAME_ERR pulse; VALID=0, DATA unchanged; BUSY stays high until RXD returns high.
  - Then a following frame 0x81 is received correctly.
- Overrun and simultaneous read:
  - Stimulus: send 0x11 then 0x22 back-to-back without RD.
  - Required: OVERRUN pulses once, DATA=0x22, VALID=1.
  - Repeat with RD asserted exactly in the delivery cycle of 0x22: no OVERRUN, VALID=1, DATA=0x22.
- Reset mid-frame:
  - Stimulus: assert RESET=0 during data bit 4 of 0xFF, release, then send 0x5A.
  - Required: all outputs 0 immediately on assertion; only 0x5A is delivered afterwards.
- Default parameters:
  - Stimulus: 10 MHz, 115200; send 0x00, 0xFF, 0x55 with 86-clock bits and ±2% baud skew on the stimulus.
  - Required: all three bytes received correctly with no FRAME_ERR.
